// File: rtl/sram_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_arbiter_if : requester ports A/B and SRAM pad-side signals    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface sram_arbiter_if;
  logic        a_req;
  logic [20:0] a_addr;
  logic        a_we;
  logic [7:0]  a_wdata;
  logic        a_ack;
  logic [7:0]  a_rdata;

  logic        b_req;
  logic [20:0] b_addr;
  logic        b_we;
  logic [7:0]  b_wdata;
  logic        b_ack;
  logic [7:0]  b_rdata;

  logic [20:0] sram_addr;
  logic        sram_we_n;
  logic [7:0]  sram_data_out;
  logic        sram_data_oe;
  logic [7:0]  sram_data_in;
  logic        busy;

  modport slave (
    input  a_req, a_addr, a_we, a_wdata,
    input  b_req, b_addr, b_we, b_wdata,
    input  sram_data_in,
    output a_ack, a_rdata, b_ack, b_rdata,
    output sram_addr, sram_we_n, sram_data_out, sram_data_oe, busy
  );

  modport master (
    output a_req, a_addr, a_we, a_wdata,
    output b_req, b_addr, b_we, b_wdata,
    output sram_data_in,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  sram_addr, sram_we_n, sram_data_out, sram_data_oe, busy
  );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_arbiter : two-port async SRAM arbiter, A priority with        |
// |                B starvation guard, fixed-length access cycles      |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_WAIT      = 4
) (
  input  wire logic     sysclk,
  input  wire logic     power_on_reset_n,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [2:0] c_last_cnt   = 3'(ACCESS_CYCLES - 1);
  localparam logic [2:0] c_strobe_end = 3'(ACCESS_CYCLES - 2);
  localparam logic [3:0] c_max_wait   = 4'(MAX_WAIT);

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_cnt;
  logic [3:0]  r_starve;
  logic        r_sel_b;
  logic        r_we;
  logic [20:0] r_addr;
  logic [7:0]  r_data_out;
  logic        r_we_n;
  logic        r_oe;
  logic        r_a_ack;
  logic        r_b_ack;
  logic [7:0]  r_a_rdata;
  logic [7:0]  r_b_rdata;

  logic        w_any_req;
  logic        w_grant_b;
  logic        w_last;
  logic        w_sel_we;
  logic [20:0] w_sel_addr;
  logic [7:0]  w_sel_wdata;

  assign w_any_req   = bus.a_req | bus.b_req;
  // B wins when A is idle, or once A has been granted MAX_WAIT times in a row
  assign w_grant_b   = bus.b_req & (~bus.a_req | (r_starve == c_max_wait));
  assign w_sel_we    = w_grant_b ? bus.b_we    : bus.a_we;
  assign w_sel_addr  = w_grant_b ? bus.b_addr  : bus.a_addr;
  assign w_sel_wdata = w_grant_b ? bus.b_wdata : bus.a_wdata;
  assign w_last      = (r_cnt == c_last_cnt);

  always_ff @(posedge sysclk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_req) w_next_state = ST_ACCESS;
      ST_ACCESS: if (w_last)    w_next_state = ST_DONE;
      ST_DONE:                  w_next_state = ST_IDLE;
      default:                  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      r_cnt      <= '0;
      r_starve   <= '0;
      r_sel_b    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data_out <= '0;
      r_we_n     <= 1'b1;
      r_oe       <= 1'b0;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!bus.b_req || w_grant_b) begin
            r_starve <= '0;
          end else if (r_starve != c_max_wait) begin
            r_starve <= r_starve + 4'd1;
          end
          if (w_any_req) begin
            r_sel_b    <= w_grant_b;
            r_we       <= w_sel_we;
            r_addr     <= w_sel_addr;
            r_data_out <= w_sel_wdata;
            r_cnt      <= '0;
            r_we_n     <= ~w_sel_we;
            r_oe       <= w_sel_we;
          end
        end
        ST_ACCESS: begin
          if (w_last) begin
            r_we_n  <= 1'b1;
            r_oe    <= 1'b0;
            r_a_ack <= ~r_sel_b;
            r_b_ack <= r_sel_b;
            if (!r_we) begin
              if (r_sel_b) begin
                r_b_rdata <= bus.sram_data_in;
              end else begin
                r_a_rdata <= bus.sram_data_in;
              end
            end
          end else begin
            r_cnt  <= r_cnt + 3'd1;
            // strobe rises one cycle before the end so addr/data are held past it
            r_we_n <= ~(r_we & (r_cnt < c_strobe_end));
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sram_addr     = r_addr;
  assign bus.sram_we_n     = r_we_n;
  assign bus.sram_data_out = r_data_out;
  assign bus.sram_data_oe  = r_oe;
  assign bus.a_ack         = r_a_ack;
  assign bus.b_ack         = r_b_ack;
  assign bus.a_rdata       = r_a_rdata;
  assign bus.b_rdata       = r_b_rdata;
  assign bus.busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sram_arbiter : directed vectors plus randomized traffic against |
// |                   a transaction-level reference model              |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_sram_arbiter;
  localparam int AC = 2;
  localparam int MW = 4;

  logic sysclk = 1'b0;
  logic rst_n;
  always #5 sysclk = ~sysclk;

  sram_arbiter_if bus ();

  sram_arbiter #(.ACCESS_CYCLES(AC), .MAX_WAIT(MW)) dut (
    .sysclk           (sysclk),
    .power_on_reset_n (rst_n),
    .bus              (bus)
  );

  int n_checks;
  int n_fail;

  logic [7:0] mem    [logic [20:0]];
  logic [7:0] refmem [logic [20:0]];

  logic        d_req [2];
  logic        d_we  [2];
  logic [20:0] d_addr[2];
  logic [7:0]  d_wd  [2];

  int          m_busy;
  int          m_starve;
  logic        m_pb;
  logic        m_we;
  logic [20:0] m_addr;
  logic [7:0]  m_wd;
  logic [7:0]  m_exp;
  logic [7:0]  m_rd[2];

  typedef struct {
    logic        pb;
    logic        we;
    logic [20:0] addr;
    logic [7:0]  wd;
    logic [7:0]  exp_rd;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [7:0] init_val(input logic [20:0] a);
    if (a == 21'h012345) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [20:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [20:0] a);
    return refmem.exists(a) ? refmem[a] : init_val(a);
  endfunction

  // SRAM device: writes on rising edge while strobe is low, read data settles by falling edge
  initial begin
    forever begin
      @(posedge sysclk);
      if (bus.sram_we_n === 1'b0) mem[bus.sram_addr] = bus.sram_data_out;
    end
  end
  initial begin
    forever begin
      @(negedge sysclk);
      bus.sram_data_in = mem_rd(bus.sram_addr);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic push();
    bus.a_req   = d_req[0];
    bus.a_we    = d_we[0];
    bus.a_addr  = d_addr[0];
    bus.a_wdata = d_wd[0];
    bus.b_req   = d_req[1];
    bus.b_we    = d_we[1];
    bus.b_addr  = d_addr[1];
    bus.b_wdata = d_wd[1];
  endtask

  task automatic rand_content(input int p);
    d_we[p]   = 1'($urandom_range(0, 1));
    d_addr[p] = 21'h0A0400 + 21'($urandom_range(0, 15));
    d_wd[p]   = 8'($urandom);
  endtask

  task automatic model_step();
    logic gb;
    if (m_busy == 0) begin
      if (!d_req[1]) m_starve = 0;
      if (d_req[0] || d_req[1]) begin
        gb = d_req[1] && (!d_req[0] || m_starve == MW);
        if (gb) m_starve = 0;
        else if (d_req[1] && m_starve < MW) m_starve++;
        m_pb   = gb;
        m_we   = d_we[gb];
        m_addr = d_addr[gb];
        m_wd   = d_wd[gb];
        if (m_we) refmem[m_addr] = m_wd;
        else      m_exp = ref_rd(m_addr);
        m_busy = AC + 1;
      end
    end else begin
      m_busy--;
    end
  endtask

  task automatic run_single(input int idx, input logic pb, input logic we, input logic [20:0] addr,
                            input logic [7:0] wd, input logic [7:0] exp_rd);
    int   ack_at, acks, other, wen_lo, oe_hi, bad;
    logic my_ack, ot_ack;
    ack_at = -1; acks = 0; other = 0; wen_lo = 0; oe_hi = 0; bad = 0;
    d_req[pb] = 1'b1; d_we[pb] = we; d_addr[pb] = addr; d_wd[pb] = wd;
    push();
    for (int j = 0; j < AC + 4; j++) begin
      @(negedge sysclk);
      if (j < AC && bus.sram_addr !== addr) bad++;
      if (j == 0 && we && bus.sram_data_out !== wd) bad++;
      if (bus.sram_we_n === 1'b0) wen_lo++;
      if (bus.sram_data_oe === 1'b1) oe_hi++;
      my_ack = pb ? bus.b_ack : bus.a_ack;
      ot_ack = pb ? bus.a_ack : bus.b_ack;
      if (ot_ack === 1'b1) other++;
      if (my_ack === 1'b1) begin
        acks++;
        if (ack_at < 0) ack_at = j;
        d_req[pb] = 1'b0;
        push();
      end
    end
    d_req[pb] = 1'b0;
    push();
    chk($sformatf("tbl%0d_ack_latency", idx), ack_at, AC);
    chk($sformatf("tbl%0d_ack_count", idx), acks, 1);
    chk($sformatf("tbl%0d_other_ack", idx), other, 0);
    chk($sformatf("tbl%0d_we_n_low_cycles", idx), wen_lo, we ? AC - 1 : 0);
    chk($sformatf("tbl%0d_oe_cycles", idx), oe_hi, we ? AC : 0);
    chk($sformatf("tbl%0d_addr_data_hold", idx), bad, 0);
    chk($sformatf("tbl%0d_busy_after", idx), bus.busy, 1'b0);
    chk($sformatf("tbl%0d_rdata", idx), pb ? bus.b_rdata : bus.a_rdata, exp_rd);
  endtask

  initial begin
    int   got_n, overlap, s, acks, idx;
    logic grant_seq[10];
    logic ack_v[2];
    logic e;

    n_checks = 0;
    n_fail   = 0;
    tbl[0] = '{1'b0, 1'b0, 21'h012345, 8'h00, 8'hA5};
    tbl[1] = '{1'b1, 1'b1, 21'h1FFFFF, 8'h3C, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 21'h1FFFFF, 8'h00, 8'h3C};
    tbl[3] = '{1'b0, 1'b1, 21'h000000, 8'h5A, 8'hA5};
    tbl[4] = '{1'b0, 1'b0, 21'h000000, 8'h00, 8'h5A};
    tbl[5] = '{1'b1, 1'b0, 21'h012345, 8'h00, 8'hA5};
    tbl[6] = '{1'b0, 1'b1, 21'h012345, 8'hC3, 8'h5A};
    tbl[7] = '{1'b0, 1'b0, 21'h012345, 8'h00, 8'hC3};

    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      d_req[p] = 1'b0; d_we[p] = 1'b0; d_addr[p] = '0; d_wd[p] = '0;
    end
    push();
    repeat (3) @(negedge sysclk);
    chk("rst_a_ack", bus.a_ack, 1'b0);
    chk("rst_b_ack", bus.b_ack, 1'b0);
    chk("rst_a_rdata", bus.a_rdata, 8'h00);
    chk("rst_b_rdata", bus.b_rdata, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_we_n", bus.sram_we_n, 1'b1);
    chk("rst_oe", bus.sram_data_oe, 1'b0);
    chk("rst_addr", bus.sram_addr, 21'h0);
    chk("rst_data_out", bus.sram_data_out, 8'h00);
    rst_n = 1'b1;
    @(negedge sysclk);
    chk("post_rst_busy", bus.busy, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_single(i, tbl[i].pb, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].exp_rd);
    end
    chk("sram_holds_1fffff", mem_rd(21'h1FFFFF), 8'h3C);

    // both ports hold req continuously
    d_we[0] = 1'b0; d_addr[0] = 21'h000000;
    d_we[1] = 1'b0; d_addr[1] = 21'h012345;
    d_req[0] = 1'b1; d_req[1] = 1'b1;
    push();
    got_n = 0; overlap = 0;
    for (int c = 0; c < 200 && got_n < 10; c++) begin
      @(negedge sysclk);
      if (bus.a_ack === 1'b1 && bus.b_ack === 1'b1) overlap++;
      if (bus.a_ack === 1'b1 || bus.b_ack === 1'b1) begin
        grant_seq[got_n] = bus.b_ack;
        got_n++;
      end
      if (got_n == 10) begin
        d_req[0] = 1'b0; d_req[1] = 1'b0;
        push();
      end
    end
    d_req[0] = 1'b0; d_req[1] = 1'b0;
    push();
    chk("starve_grant_count", got_n, 10);
    chk("starve_ack_overlap", overlap, 0);
    s = 0;
    for (int k = 0; k < 10; k++) begin
      e = (s == MW);
      s = e ? 0 : s + 1;
      chk($sformatf("starve_grant%0d_is_b", k), grant_seq[k], e);
    end
    repeat (2) @(negedge sysclk);
    chk("starve_a_rdata", bus.a_rdata, 8'h5A);
    chk("starve_b_rdata", bus.b_rdata, 8'hC3);

    // reset during the first ACCESS cycle of a write
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 21'h000100; d_wd[0] = 8'h77;
    push();
    @(negedge sysclk);
    chk("midrst_pre_we_n", bus.sram_we_n, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_we_n", bus.sram_we_n, 1'b1);
    chk("midrst_oe", bus.sram_data_oe, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_a_rdata", bus.a_rdata, 8'h00);
    d_req[0] = 1'b0;
    push();
    @(negedge sysclk);
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge sysclk);
      if (bus.a_ack === 1'b1 || bus.b_ack === 1'b1) acks++;
    end
    chk("midrst_no_ack", acks, 0);
    chk("midrst_idle", bus.busy, 1'b0);
    run_single(8, 1'b0, 1'b1, 21'h000100, 8'h77, 8'h00);
    run_single(9, 1'b0, 1'b0, 21'h000100, 8'h00, 8'h77);

    // a_req dropped in the first ACCESS cycle
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 21'h012345;
    push();
    @(negedge sysclk);
    d_req[0] = 1'b0;
    push();
    acks = 0;
    repeat (AC + 3) begin
      @(negedge sysclk);
      if (bus.a_ack === 1'b1) acks++;
    end
    chk("early_drop_ack_count", acks, 1);
    chk("early_drop_idle", bus.busy, 1'b0);
    chk("early_drop_rdata", bus.a_rdata, 8'hC3);

    // randomized traffic against the reference model
    rst_n = 1'b0;
    d_req[0] = 1'b0; d_req[1] = 1'b0;
    push();
    @(negedge sysclk);
    rst_n = 1'b1;
    m_busy = 0; m_starve = 0; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
    m_pb = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0; m_exp = '0;
    model_step();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge sysclk);
      idx = AC + 1 - m_busy;
      if (m_busy == 1 && !m_we) m_rd[m_pb] = m_exp;
      chk("rnd_busy", bus.busy, m_busy > 0);
      chk("rnd_a_ack", bus.a_ack, (m_busy == 1) && !m_pb);
      chk("rnd_b_ack", bus.b_ack, (m_busy == 1) && m_pb);
      chk("rnd_we_n", bus.sram_we_n, !(m_busy >= 2 && m_we && idx <= AC - 2));
      chk("rnd_oe", bus.sram_data_oe, (m_busy >= 2) && m_we);
      chk("rnd_a_rdata", bus.a_rdata, m_rd[0]);
      chk("rnd_b_rdata", bus.b_rdata, m_rd[1]);
      if (m_busy >= 2) chk("rnd_addr", bus.sram_addr, m_addr);
      if (m_busy >= 2 && m_we) chk("rnd_data_out", bus.sram_data_out, m_wd);
      ack_v[0] = bus.a_ack;
      ack_v[1] = bus.b_ack;
      for (int p = 0; p < 2; p++) begin
        if (ack_v[p] === 1'b1) begin
          if ($urandom_range(0, 1) == 0) d_req[p] = 1'b0;
          else rand_content(p);
        end else if (!d_req[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            d_req[p] = 1'b1;
            rand_content(p);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          rand_content(p);
        end
      end
      push();
      model_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
